stack_bus_master: RTL and testbench

- Initiator for the 5-entry 4-bit stack bus: COMMAND 00 nop, 01 push, 10 pop, 11 get-at-INDEX, with a shared bidirectional 4-bit data line.
- Accepts host requests through a valid/ready handshake, sequences the stack-side command/data pins, captures read data, and returns one response per request.
- Tracks stack occupancy so host-visible overflow, underflow and bad-index requests are rejected instead of wrapping silently.

---
 rtl/stack_bus_master.sv | 110 +++++++++++
 tb/tb_stack_bus_master.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/stack_bus_master.sv
// Host-side initiator for the 4-bit command/data stack bus. Turns valid/ready
// requests into CMD/HOLD bus sequences and returns one response per request.
module stack_bus_master #(
  parameter  int DEPTH = 5,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [1:0]    REQ_OP,
  input  logic [2:0]    REQ_INDEX,
  input  logic [3:0]    REQ_DATA,
  output logic          RSP_VALID,
  output logic [3:0]    RSP_DATA,
  output logic          RSP_ERR,
  output logic [1:0]    ST_CMD,
  output logic [2:0]    ST_INDEX,
  inout  wire  [3:0]    ST_DATA,
  output logic [CW-1:0] COUNT,
  output logic          FULL,
  output logic          EMPTY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_GET  = 2'b11;

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic [1:0]    r_op;
  logic [2:0]    r_index;
  logic [3:0]    r_data;
  logic          r_err;
  logic [3:0]    r_cap;
  logic          w_reject;
  logic          w_drv;

  always_comb begin
    w_reject = 1'b0;
    case (REQ_OP)
      OP_PUSH: w_reject = (r_count == CW'(DEPTH));
      OP_POP:  w_reject = (r_count == '0);
      OP_GET:  w_reject = (int'(REQ_INDEX) >= int'(r_count));
      default: w_reject = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_op    <= OP_NOP;
      r_index <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (REQ_VALID) begin
          r_op    <= REQ_OP;
          r_index <= (REQ_OP == OP_GET) ? REQ_INDEX : 3'd0;
          r_data  <= REQ_DATA;
          r_err   <= w_reject;
          // rejects and no-ops answer immediately without touching the bus
          r_state <= (w_reject || REQ_OP == OP_NOP) ? S_RESP : S_CMD;
        end
        S_CMD: begin
          if (r_op == OP_PUSH) begin
            r_count <= r_count + 1'b1;
            r_state <= S_RESP;
          end else begin
            if (r_op == OP_POP) r_count <= r_count - 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD:  r_state <= S_RESP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stack drives the bus through the high phase of HOLD; sample mid-cycle.
  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET)                  r_cap <= '0;
    else if (r_state == S_HOLD) r_cap <= ST_DATA;
  end

  // HOLD issues a side-effect-free get so the stack keeps driving read data.
  assign ST_CMD    = (r_state == S_CMD)  ? r_op :
                     (r_state == S_HOLD) ? OP_GET : OP_NOP;
  assign ST_INDEX  = (r_state == S_CMD || r_state == S_HOLD) ? r_index : 3'd0;
  assign w_drv     = (r_state == S_CMD) && (r_op == OP_PUSH);
  assign ST_DATA   = w_drv ? r_data : 4'bzzzz;

  assign REQ_READY = (r_state == S_IDLE);
  assign RSP_VALID = (r_state == S_RESP);
  assign RSP_ERR   = (r_state == S_RESP) && r_err;
  assign RSP_DATA  = (r_state == S_RESP && !r_err && r_op[1]) ? r_cap : 4'd0;

  assign COUNT = r_count;
  assign FULL  = (r_count == CW'(DEPTH));
  assign EMPTY = (r_count == '0);

endmodule

// File: tb/tb_stack_bus_master.sv
// Directed bench for stack_bus_master with a behavioural 5-entry stack on the
// bus and a response scoreboard (data, error, latency, ST_CMD sequence).
`timescale 1ns/1ps
module tb_stack_bus_master;
  localparam int DEPTH = 5;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [1:0] REQ_OP;
  logic [2:0] REQ_INDEX;
  logic [3:0] REQ_DATA;
  logic       RSP_VALID;
  logic [3:0] RSP_DATA;
  logic       RSP_ERR;
  logic [1:0] ST_CMD;
  logic [2:0] ST_INDEX;
  wire  [3:0] st_data;
  logic [2:0] COUNT;
  logic       FULL;
  logic       EMPTY;

  typedef struct packed {
    logic [3:0] data;
    logic       err;
    logic [3:0] lat;
    logic [7:0] seq;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 CLK = ~CLK;

  stack_bus_master #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_INDEX(REQ_INDEX), .REQ_DATA(REQ_DATA),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .ST_CMD(ST_CMD), .ST_INDEX(ST_INDEX), .ST_DATA(st_data),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY)
  );

  // Behavioural stack: drives read data whenever COMMAND is pop or get.
  logic [3:0] mem [DEPTH];
  int         sp;
  logic [3:0] s_out;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sp    <= 0;
      s_out <= '0;
    end else begin
      case (ST_CMD)
        2'b01: if (sp < DEPTH) begin mem[sp] <= st_data; sp <= sp + 1; end
        2'b10: if (sp > 0) begin s_out <= mem[sp-1]; sp <= sp - 1; end
        2'b11: if (int'(ST_INDEX) < sp) s_out <= mem[sp-1-int'(ST_INDEX)];
        default: ;
      endcase
    end
  end
  assign st_data = ST_CMD[1] ? s_out : 4'bzzzz;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_req(input string tag, input logic [1:0] op, input logic [2:0] idx,
                        input logic [3:0] d, input logic [3:0] exp_d, input logic exp_err);
    exp_t e, g;
    logic [3:0] lat;
    logic [7:0] seq;
    logic [3:0] d1, d2;
    logic       got;
    e.data = (exp_err || !op[1]) ? 4'd0 : exp_d;
    e.err  = exp_err;
    if (exp_err || op == 2'b00) begin e.lat = 1; e.seq = 8'h00; end
    else if (op == 2'b01)       begin e.lat = 2; e.seq = {4'b0, 2'b01, 2'b00}; end
    else                        begin e.lat = 3; e.seq = {2'b0, op, 2'b11, 2'b00}; end
    @(negedge CLK);
    check({tag, "_ready"}, {7'd0, REQ_READY}, 8'd1);
    REQ_VALID = 1'b1; REQ_OP = op; REQ_INDEX = idx; REQ_DATA = d;
    sb.push_back(e);
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    lat = 0; seq = 0; d1 = 0; d2 = 0; got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge CLK);
      lat++;
      seq = {seq[5:0], ST_CMD};
      if (lat == 1) d1 = st_data;
      if (lat == 2) d2 = st_data;
      if (RSP_VALID) got = 1'b1;
    end
    check({tag, "_rsp_seen"}, {7'd0, got}, 8'd1);
    if (got) begin
      g = sb.pop_front();
      check({tag, "_data"}, {4'd0, RSP_DATA}, {4'd0, g.data});
      check({tag, "_err"},  {7'd0, RSP_ERR},  {7'd0, g.err});
      check({tag, "_lat"},  {4'd0, lat},      {4'd0, g.lat});
      check({tag, "_cmdseq"}, seq, g.seq);
      if (op == 2'b01 && !exp_err) check({tag, "_bus_push"}, {4'd0, d1}, {4'd0, d});
      if (op[1] && !exp_err) begin
        check({tag, "_bus_known"}, {7'd0, $isunknown(d2)}, 8'd0);
        check({tag, "_bus_hold"}, {4'd0, d2}, {4'd0, exp_d});
      end
    end else begin
      void'(sb.pop_front());
    end
  endtask

  initial begin
    logic seen;
    RESET = 1'b1; REQ_VALID = 1'b0; REQ_OP = 2'b00; REQ_INDEX = '0; REQ_DATA = '0;
    repeat (2) @(negedge CLK);
    check("rst_count", {5'd0, COUNT}, 8'd0);
    check("rst_stcmd", {6'd0, ST_CMD}, 8'd0);
    check("rst_rsp",   {3'd0, RSP_VALID, RSP_DATA}, 8'd0);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_ready", {7'd0, REQ_READY}, 8'd1);
    check("rst_empty", {6'd0, EMPTY, FULL}, 8'd2);

    do_req("nop",   2'b00, 3'd0, 4'd5, 4'd0, 1'b0);
    do_req("push3", 2'b01, 3'd0, 4'd3, 4'd0, 1'b0);
    do_req("push7", 2'b01, 3'd0, 4'd7, 4'd0, 1'b0);
    do_req("push9", 2'b01, 3'd0, 4'd9, 4'd0, 1'b0);
    check("count3", {5'd0, COUNT}, 8'd3);
    do_req("get2", 2'b11, 3'd2, 4'd0, 4'd3, 1'b0);
    do_req("get0", 2'b11, 3'd0, 4'd0, 4'd9, 1'b0);
    do_req("get3", 2'b11, 3'd3, 4'd0, 4'd0, 1'b1);
    do_req("pop9", 2'b10, 3'd0, 4'd0, 4'd9, 1'b0);
    do_req("pop7", 2'b10, 3'd0, 4'd0, 4'd7, 1'b0);
    do_req("pop3", 2'b10, 3'd0, 4'd0, 4'd3, 1'b0);
    check("empty", {6'd0, EMPTY, FULL}, 8'd2);
    do_req("pop_uf", 2'b10, 3'd0, 4'd0, 4'd0, 1'b1);
    for (int v = 1; v <= 5; v++)
      do_req("pushn", 2'b01, 3'd0, 4'(v), 4'd0, 1'b0);
    check("full", {6'd0, EMPTY, FULL}, 8'd1);
    check("count5", {5'd0, COUNT}, 8'd5);
    do_req("push_of", 2'b01, 3'd0, 4'd6, 4'd0, 1'b1);
    check("count5b", {5'd0, COUNT}, 8'd5);
    do_req("get4", 2'b11, 3'd4, 4'd0, 4'd1, 1'b0);
    do_req("pop5", 2'b10, 3'd0, 4'd0, 4'd5, 1'b0);
    do_req("pop4", 2'b10, 3'd0, 4'd0, 4'd4, 1'b0);
    do_req("push8", 2'b01, 3'd0, 4'd8, 4'd0, 1'b0);
    check("count4", {5'd0, COUNT}, 8'd4);

    // Reset in the HOLD cycle of a pop
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_OP = 2'b10; REQ_INDEX = '0;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("abort_in_hold", {6'd0, ST_CMD}, 8'h03);
    RESET = 1'b1;
    #1;
    check("abort_count", {5'd0, COUNT}, 8'd0);
    check("abort_stcmd", {6'd0, ST_CMD}, 8'd0);
    seen = RSP_VALID;
    @(negedge CLK);
    RESET = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (RSP_VALID) seen = 1'b1;
    end
    check("abort_no_rsp", {7'd0, seen}, 8'd0);
    check("abort_ready", {7'd0, REQ_READY}, 8'd1);
    do_req("get_after_rst", 2'b11, 3'd0, 4'd0, 4'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
